// File: rtl/int_priority_controller.sv
// Nested priority interrupt controller: synchronizes and edge-detects the pins, latches
// pending events, and issues one request at a time to the core through a req/take handshake.
module int_priority_controller #(
  parameter int unsigned NumSrc = 3,
  parameter int unsigned IdBit  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NumSrc-1:0] irq,
  input  logic              ie,
  input  logic              take,
  input  logic              eret,
  output logic              req,
  output logic [IdBit-1:0]  req_id,
  output logic [NumSrc-1:0] pending,
  output logic [NumSrc-1:0] active,
  output logic [IdBit-1:0]  depth
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [NumSrc-1:0] sync1_q;
  logic [NumSrc-1:0] sync2_q;
  logic [NumSrc-1:0] edge_q;
  logic [NumSrc-1:0] rise;
  logic [NumSrc-1:0] allowed;
  logic [NumSrc-1:0] top_oh;
  logic [NumSrc-1:0] take_oh;
  logic [NumSrc-1:0] pending_d;
  logic [NumSrc-1:0] active_d;
  logic [IdBit-1:0]  cand_id;
  logic [IdBit-1:0]  req_id_d;
  logic [IdBit-1:0]  depth_d;
  logic              cand_valid;
  logic              eligible;
  logic              take_fire;
  logic              withdraw;

  // Pin capture: two-stage synchronizer followed by a rising-edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~edge_q;

  // Candidate must sit strictly above every in-service level
  always_comb begin
    logic seen;
    seen       = 1'b0;
    allowed    = '0;
    top_oh     = '0;
    cand_valid = 1'b0;
    cand_id    = '0;
    for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
      seen       = seen | active[i];
      allowed[i] = ~seen;
    end
    for (int i = 0; i < int'(NumSrc); i++) begin
      if (active[i]) begin
        top_oh    = '0;
        top_oh[i] = 1'b1;
      end
      if (pending[i] && allowed[i]) begin
        cand_valid = 1'b1;
        cand_id    = IdBit'(i);
      end
    end
  end

  assign eligible = cand_valid & ie & en;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the frozen request id
  always_comb begin
    state_d  = state_q;
    req_id_d = '0;
    case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d  = REQ;
          req_id_d = cand_id;
        end
      end
      REQ: begin
        if (take || !ie || !en) begin
          state_d = IDLE;
        end else begin
          req_id_d = req_id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req       = 1'b0;
    take_fire = 1'b0;
    withdraw  = 1'b0;
    if (state_q == REQ) begin
      req       = 1'b1;
      take_fire = take;
      withdraw  = ~take & (~ie | ~en);
    end
  end

  // Pending/active updates; a same-cycle edge on the taken source survives the clear
  always_comb begin
    int unsigned cnt;
    take_oh   = take_fire ? (NumSrc'(1) << req_id) : '0;
    pending_d = (pending & ~take_oh) | rise;
    active_d  = (eret ? (active & ~top_oh) : active) | take_oh;
    cnt       = 0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      if (active_d[i]) cnt++;
    end
    depth_d = IdBit'(cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
      depth   <= '0;
      req_id  <= '0;
    end else begin
      pending <= pending_d;
      active  <= active_d;
      depth   <= depth_d;
      req_id  <= req_id_d;
    end
  end

endmodule

// File: tb/tb_int_priority_controller.sv
// Directed bench for int_priority_controller with a queued expected-snapshot scoreboard.
module tb_int_priority_controller;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] irq;
  logic       ie;
  logic       take;
  logic       eret;
  logic       req;
  logic [1:0] req_id;
  logic [2:0] pending;
  logic [2:0] active;
  logic [1:0] depth;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;

  sb_t sb[$];

  int_priority_controller #(.NumSrc(3), .IdBit(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .irq     (irq),
    .ie      (ie),
    .take    (take),
    .eret    (eret),
    .req     (req),
    .req_id  (req_id),
    .pending (pending),
    .active  (active),
    .depth   (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot layout: {req, req_id, pending, active, depth}
  function automatic logic [10:0] mk(input logic r, input logic [1:0] id,
                                     input logic [2:0] p, input logic [2:0] a,
                                     input logic [1:0] d);
    return {r, id, p, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare();
    sb_t         it;
    logic [10:0] obs;
    it  = sb.pop_front();
    obs = {req, req_id, pending, active, depth};
    vectors++;
    assert (obs === it.exp) else begin
      miscompares++;
      $display("FAIL %s: observed req/id/pend/act/depth=%b required %b", it.tag, obs, it.exp);
      $error("check %s", it.tag);
    end
  endtask

  task automatic check_now(input string tag, input logic [10:0] exp);
    sb.push_back('{tag, exp});
    compare();
  endtask

  task automatic step(input string tag, input logic [10:0] exp);
    sb.push_back('{tag, exp});
    tick();
    compare();
  endtask

  task automatic pulse(input int i);
    irq[i] = 1'b1;
    tick();
    irq[i] = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    ie    = 1'b1;
    irq   = '0;
    take  = 1'b0;
    eret  = 1'b0;
    tick();
    tick();
    check_now("reset", mk(0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Single source: three edges to pending, one more to req
    pulse(0);
    step("s1_sync", mk(0, 0, 3'b000, 3'b000, 0));
    step("s1_pend", mk(0, 0, 3'b001, 3'b000, 0));
    step("s1_req",  mk(1, 0, 3'b001, 3'b000, 0));
    take = 1'b1;
    step("s1_take", mk(0, 0, 3'b000, 3'b001, 1));
    take = 1'b0;

    // Nesting over an active level 0
    pulse(2);
    tick();
    step("n_pend", mk(0, 0, 3'b100, 3'b001, 1));
    step("n_req",  mk(1, 2, 3'b100, 3'b001, 1));
    take = 1'b1;
    step("n_take", mk(0, 0, 3'b000, 3'b101, 2));
    take = 1'b0;
    pulse(1);
    tick();
    step("n_low_pend",   mk(0, 0, 3'b010, 3'b101, 2));
    step("n_low_noreq",  mk(0, 0, 3'b010, 3'b101, 2));
    step("n_low_noreq2", mk(0, 0, 3'b010, 3'b101, 2));
    eret = 1'b1;
    step("n_eret", mk(0, 0, 3'b010, 3'b001, 1));
    eret = 1'b0;
    step("n_low_req", mk(1, 1, 3'b010, 3'b001, 1));

    // Withdraw on ie low, then reissue
    ie = 1'b0;
    step("wd_drop", mk(0, 0, 3'b010, 3'b001, 1));
    ie = 1'b1;
    step("wd_reissue", mk(1, 1, 3'b010, 3'b001, 1));
    take = 1'b1;
    step("wd_take", mk(0, 0, 3'b000, 3'b011, 2));
    take = 1'b0;

    // Unwind, then spurious eret/take
    eret = 1'b1;
    step("eret_a",    mk(0, 0, 3'b000, 3'b001, 1));
    step("eret_b",    mk(0, 0, 3'b000, 3'b000, 0));
    step("eret_idle", mk(0, 0, 3'b000, 3'b000, 0));
    eret = 1'b0;
    take = 1'b1;
    step("take_idle", mk(0, 0, 3'b000, 3'b000, 0));
    take = 1'b0;

    // Frozen id while a higher edge arrives during REQ
    pulse(0);
    tick();
    step("fz_pend", mk(0, 0, 3'b001, 3'b000, 0));
    step("fz_req",  mk(1, 0, 3'b001, 3'b000, 0));
    irq[2] = 1'b1;
    step("fz_a", mk(1, 0, 3'b001, 3'b000, 0));
    irq[2] = 1'b0;
    step("fz_b", mk(1, 0, 3'b001, 3'b000, 0));
    step("fz_c", mk(1, 0, 3'b101, 3'b000, 0));
    step("fz_d", mk(1, 0, 3'b101, 3'b000, 0));
    take = 1'b1;
    step("fz_take", mk(0, 0, 3'b100, 3'b001, 1));
    take = 1'b0;
    step("fz_req2", mk(1, 2, 3'b100, 3'b001, 1));
    take = 1'b1;
    step("fz_take2", mk(0, 0, 3'b000, 3'b101, 2));
    take = 1'b0;
    eret = 1'b1;
    step("fz_eret1", mk(0, 0, 3'b000, 3'b001, 1));
    step("fz_eret2", mk(0, 0, 3'b000, 3'b000, 0));
    eret = 1'b0;

    // Same-cycle take and eret
    pulse(1);
    tick();
    step("sc_pend1", mk(0, 0, 3'b010, 3'b000, 0));
    step("sc_req1",  mk(1, 1, 3'b010, 3'b000, 0));
    take = 1'b1;
    step("sc_take1", mk(0, 0, 3'b000, 3'b010, 1));
    take = 1'b0;
    pulse(2);
    tick();
    step("sc_pend2", mk(0, 0, 3'b100, 3'b010, 1));
    step("sc_req2",  mk(1, 2, 3'b100, 3'b010, 1));
    take = 1'b1;
    eret = 1'b1;
    step("sc_both", mk(0, 0, 3'b000, 3'b100, 1));
    take = 1'b0;
    eret = 1'b0;
    step("sc_after", mk(0, 0, 3'b000, 3'b100, 1));
    eret = 1'b1;
    step("sc_eret", mk(0, 0, 3'b000, 3'b000, 0));
    eret = 1'b0;

    // Pin held high through reset yields exactly one event
    irq[1] = 1'b1;
    rst_n  = 1'b0;
    tick();
    tick();
    check_now("rh_in_reset", mk(0, 0, 3'b000, 3'b000, 0));
    rst_n = 1'b1;
    step("rh_1",    mk(0, 0, 3'b000, 3'b000, 0));
    step("rh_2",    mk(0, 0, 3'b000, 3'b000, 0));
    step("rh_pend", mk(0, 0, 3'b010, 3'b000, 0));
    step("rh_req",  mk(1, 1, 3'b010, 3'b000, 0));
    take = 1'b1;
    step("rh_take", mk(0, 0, 3'b000, 3'b010, 1));
    take = 1'b0;
    for (int k = 0; k < 3; k++) step("rh_once", mk(0, 0, 3'b000, 3'b010, 1));
    irq[1] = 1'b0;

    // Reset mid-handshake clears everything immediately and loses the request
    eret = 1'b1;
    step("mr_eret", mk(0, 0, 3'b000, 3'b000, 0));
    eret = 1'b0;
    pulse(0);
    tick();
    step("mr_pend", mk(0, 0, 3'b001, 3'b000, 0));
    step("mr_req",  mk(1, 0, 3'b001, 3'b000, 0));
    rst_n = 1'b0;
    #1;
    check_now("mr_reset", mk(0, 0, 3'b000, 3'b000, 0));
    tick();
    rst_n = 1'b1;
    step("mr_lost1", mk(0, 0, 3'b000, 3'b000, 0));
    step("mr_lost2", mk(0, 0, 3'b000, 3'b000, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
